// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the pipeline stage register: state encoding and occupancy width.
// The state encoding is chosen so the state value doubles as the occupancy count.
package pipe_pkg;

   localparam int PIPE_OCC_W = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } pipe_state_t;

   function automatic logic [PIPE_OCC_W-1:0] state_to_occ(input pipe_state_t state);
      logic [PIPE_OCC_W-1:0] occ;
      occ = '0;
      case (state)
         EMPTY:   occ = 2'd0;
         ONE:     occ = 2'd1;
         TWO:     occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle around one pipeline stage: upstream valid/ready/payload,
// downstream valid/ready/payload and the occupancy status.
interface pipe_stage_reg_if #(
   parameter int WIDTH = 32
);
   import pipe_pkg::*;

   logic                  valid_i;
   logic                  ready_o;
   logic [WIDTH-1:0]      write_i;
   logic                  valid_o;
   logic                  ready_i;
   logic [WIDTH-1:0]      read_o;
   logic [PIPE_OCC_W-1:0] occ_o;

   // The stage itself is the slave; the surrounding pipeline or a bench is the master.
   modport slave (
      input  valid_i,
      input  write_i,
      input  ready_i,
      output ready_o,
      output valid_o,
      output read_o,
      output occ_o
   );

   modport master (
      output valid_i,
      output write_i,
      output ready_i,
      input  ready_o,
      input  valid_o,
      input  read_o,
      input  occ_o
   );

endinterface

// File: rtl/pipe_data_reg.sv
// Payload register with load enable, synchronous clear and asynchronous reset,
// both of which return it to RESET_VAL. Clear takes priority over load.
module pipe_data_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         q_o <= RESET_VAL;
      end else if (clear_i) begin
         q_o <= RESET_VAL;
      end else if (load_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that makes ready_o a pure register decode.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               SKID      = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             flush_i,
   pipe_stage_reg_if.slave  bus
);

   pipe_state_t      state_q;
   pipe_state_t      state_d;
   logic             stage_valid;
   logic             stage_ready;
   logic             in_fire;
   logic             out_fire;
   logic             main_load;
   logic             main_from_skid;
   logic             skid_load;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   assign stage_valid = (state_q != EMPTY);

   // With the skid buffer, ready depends only on state so the ready path is registered.
   generate
      if (SKID != 0) begin : g_ready_reg
         assign stage_ready = (state_q != TWO);
      end else begin : g_ready_comb
         assign stage_ready = bus.ready_i | ~stage_valid;
      end
   endgenerate

   assign in_fire  = bus.valid_i & stage_ready;
   assign out_fire = stage_valid & bus.ready_i;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_load = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_load = 1'b1;
            end else if (out_fire) begin
               state_d = EMPTY;
            end else if (in_fire && (SKID != 0)) begin
               skid_load = 1'b1;
               state_d   = TWO;
            end
         end
         TWO: begin
            if (out_fire) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      // Flush wins over everything clocked; the registers clear through their own clear input.
      if (flush_i) begin
         state_d        = EMPTY;
         main_load      = 1'b0;
         main_from_skid = 1'b0;
         skid_load      = 1'b0;
      end
   end

   assign main_d = main_from_skid ? skid_q : bus.write_i;

   pipe_data_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_main_reg (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .clear_i  (flush_i),
      .load_i   (main_load),
      .d_i      (main_d),
      .q_o      (main_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_data_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_skid_reg (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .clear_i  (flush_i),
            .load_i   (skid_load),
            .d_i      (bus.write_i),
            .q_o      (skid_q)
         );
      end else begin : g_no_skid
         logic unused_skid_load;
         assign unused_skid_load = skid_load;
         assign skid_q           = RESET_VAL;
      end
   endgenerate

   assign bus.ready_o = stage_ready;
   assign bus.valid_o = stage_valid;
   assign bus.read_o  = main_q;
   assign bus.occ_o   = state_to_occ(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, directed scenarios
// plus a long random run checked against a small FIFO model of each stage.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int          W   = 32;
   localparam logic [31:0] RV1 = 32'hDEAD_BEEF;
   localparam logic [31:0] RV0 = 32'h0000_00A5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   // Index 1 drives the SKID=1 instance, index 0 the SKID=0 instance.
   logic        vi [2] = '{1'b0, 1'b0};
   logic        ri [2] = '{1'b0, 1'b0};
   logic        fl [2] = '{1'b0, 1'b0};
   logic [31:0] di [2] = '{32'h0, 32'h0};
   logic        av [2];
   logic        ar [2];
   logic [31:0] ad [2];
   logic [1:0]  ao [2];

   int checks   = 0;
   int failures = 0;

   // Behavioural model: a bounded FIFO plus the last value shown on read_o.
   logic [31:0] md [2][2];
   int          mc [2] = '{0, 0};
   logic [31:0] ml [2] = '{RV0, RV1};

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.WIDTH(W)) bus1 ();
   pipe_stage_reg_if #(.WIDTH(W)) bus0 ();

   pipe_stage_reg #(.WIDTH(W), .SKID(1), .RESET_VAL(RV1)) dut1 (
      .clk_i(clk), .reset_ni(rst_n), .flush_i(fl[1]), .bus(bus1.slave));
   pipe_stage_reg #(.WIDTH(W), .SKID(0), .RESET_VAL(RV0)) dut0 (
      .clk_i(clk), .reset_ni(rst_n), .flush_i(fl[0]), .bus(bus0.slave));

   assign bus1.valid_i = vi[1];
   assign bus1.write_i = di[1];
   assign bus1.ready_i = ri[1];
   assign bus0.valid_i = vi[0];
   assign bus0.write_i = di[0];
   assign bus0.ready_i = ri[0];
   assign av[1] = bus1.valid_o;
   assign ar[1] = bus1.ready_o;
   assign ad[1] = bus1.read_o;
   assign ao[1] = bus1.occ_o;
   assign av[0] = bus0.valid_o;
   assign ar[0] = bus0.ready_o;
   assign ad[0] = bus0.read_o;
   assign ao[0] = bus0.occ_o;

   function automatic logic [31:0] rv_of(input int k);
      return (k == 1) ? RV1 : RV0;
   endfunction

   function automatic logic exp_ready(input int k);
      if (k == 1) return (mc[k] < 2);
      return ri[k] || (mc[k] == 0);
   endfunction

   function automatic logic [31:0] exp_read(input int k);
      return (mc[k] > 0) ? md[k][0] : ml[k];
   endfunction

   task automatic model_step(input int k);
      logic rdy;
      logic in_x;
      logic out_x;
      rdy   = exp_ready(k);
      in_x  = vi[k] && rdy;
      out_x = (mc[k] > 0) && ri[k];
      if (fl[k]) begin
         mc[k] = 0;
         ml[k] = rv_of(k);
      end else begin
         if (out_x) begin
            ml[k]    = md[k][0];
            md[k][0] = md[k][1];
            mc[k]    = mc[k] - 1;
         end
         if (in_x) begin
            md[k][mc[k]] = di[k];
            mc[k]        = mc[k] + 1;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
               mc[k] = 0;
               ml[k] = rv_of(k);
            end
         end else begin
            model_step(0);
            model_step(1);
         end
      end
   end

   task automatic applyStimulus(input int k, input logic v, input logic [31:0] d, input logic r, input logic f);
      vi[k] = v;
      di[k] = d;
      ri[k] = r;
      fl[k] = f;
   endtask

   task automatic test_reset();
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      checks++; if (bus1.read_o !== 32'h0000_1234) begin failures++; $display("[TB] FAIL pre_reset_read: got %h expected %h", bus1.read_o, 32'h0000_1234); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus1.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", bus1.valid_o); end
      checks++; if (bus1.read_o !== RV1) begin failures++; $display("[TB] FAIL reset_read: got %h expected %h", bus1.read_o, RV1); end
      checks++; if (bus1.occ_o !== 2'd0) begin failures++; $display("[TB] FAIL reset_occ: got %0d expected 0", bus1.occ_o); end
      checks++; if (bus1.ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", bus1.ready_o); end
      checks++; if (bus0.read_o !== RV0) begin failures++; $display("[TB] FAIL reset_read_s0: got %h expected %h", bus0.read_o, RV0); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         applyStimulus(1, 1'b1, 32'(i), 1'b1, 1'b0);
         #1;
         checks++; if (bus1.ready_o !== 1'b1) begin failures++; $display("[TB] FAIL stream_ready: got %b expected 1", bus1.ready_o); end
         if (i > 1) begin
            checks++; if (bus1.valid_o !== 1'b1 || bus1.read_o !== 32'(i - 1)) begin failures++; $display("[TB] FAIL stream_data: got %b/%h expected 1/%h", bus1.valid_o, bus1.read_o, 32'(i - 1)); end
         end
      end
      @(negedge clk);
      applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++; if (bus1.valid_o !== 1'b1 || bus1.read_o !== 32'h8) begin failures++; $display("[TB] FAIL stream_last: got %b/%h expected 1/8", bus1.valid_o, bus1.read_o); end
      @(negedge clk);
      #1;
      checks++; if (bus1.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain: got %b expected 0", bus1.valid_o); end
   endtask

   task automatic test_back_pressure();
      @(negedge clk);
      applyStimulus(1, 1'b1, 32'hA, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1, 1'b1, 32'hB, 1'b0, 1'b0);
      #1;
      checks++; if (bus1.read_o !== 32'hA || bus1.ready_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_a_shown: got %h/%b expected a/1", bus1.read_o, bus1.ready_o); end
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         applyStimulus(1, 1'b1, 32'hC, 1'b0, 1'b0);
         #1;
         checks++; if (bus1.occ_o !== 2'd2 || bus1.ready_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_full: got occ %0d ready %b expected occ 2 ready 0", bus1.occ_o, bus1.ready_o); end
         checks++; if (bus1.read_o !== 32'hA) begin failures++; $display("[TB] FAIL bp_hold_a: got %h expected a", bus1.read_o); end
      end
      @(negedge clk);
      applyStimulus(1, 1'b1, 32'hC, 1'b1, 1'b0);
      #1;
      checks++; if (bus1.ready_o !== 1'b0 || bus1.read_o !== 32'hA) begin failures++; $display("[TB] FAIL bp_release: got ready %b read %h expected ready 0 read a", bus1.ready_o, bus1.read_o); end
      @(negedge clk);
      #1;
      checks++; if (bus1.read_o !== 32'hB || bus1.ready_o !== 1'b1 || bus1.occ_o !== 2'd1) begin failures++; $display("[TB] FAIL bp_b_out: got %h/%b/%0d expected b/1/1", bus1.read_o, bus1.ready_o, bus1.occ_o); end
      @(negedge clk);
      applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++; if (bus1.read_o !== 32'hC || bus1.valid_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_c_out: got %h/%b expected c/1", bus1.read_o, bus1.valid_o); end
      @(negedge clk);
      #1;
      checks++; if (bus1.valid_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain: got %b expected 0", bus1.valid_o); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      applyStimulus(1, 1'b1, 32'h11, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1, 1'b1, 32'h22, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1, 1'b1, 32'h55, 1'b0, 1'b1);
      #1;
      checks++; if (bus1.occ_o !== 2'd2) begin failures++; $display("[TB] FAIL flush_pre_occ: got %0d expected 2", bus1.occ_o); end
      @(negedge clk);
      applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++; if (bus1.valid_o !== 1'b0 || bus1.occ_o !== 2'd0) begin failures++; $display("[TB] FAIL flush_empty: got valid %b occ %0d expected 0/0", bus1.valid_o, bus1.occ_o); end
      checks++; if (bus1.read_o !== RV1) begin failures++; $display("[TB] FAIL flush_read: got %h expected %h", bus1.read_o, RV1); end
      repeat (3) begin
         @(negedge clk);
         #1;
         checks++; if (bus1.valid_o !== 1'b0 || bus1.read_o === 32'h55) begin failures++; $display("[TB] FAIL flush_no_55: got %b/%h expected 0/%h", bus1.valid_o, bus1.read_o, RV1); end
      end
   endtask

   task automatic test_skid0();
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h7, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h8, 1'b0, 1'b0);
      #1;
      checks++; if (bus0.ready_o !== 1'b0 || bus0.read_o !== 32'h7 || bus0.valid_o !== 1'b1) begin failures++; $display("[TB] FAIL s0_hold: got ready %b read %h valid %b expected 0/7/1", bus0.ready_o, bus0.read_o, bus0.valid_o); end
      checks++; if (bus0.occ_o !== 2'd1) begin failures++; $display("[TB] FAIL s0_occ: got %0d expected 1", bus0.occ_o); end
      #1 ri[0] = 1'b1;
      #1;
      checks++; if (bus0.ready_o !== 1'b1) begin failures++; $display("[TB] FAIL s0_comb_ready: got %b expected 1", bus0.ready_o); end
      @(negedge clk);
      applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++; if (bus0.read_o !== 32'h8 || bus0.valid_o !== 1'b1) begin failures++; $display("[TB] FAIL s0_replace: got %h/%b expected 8/1", bus0.read_o, bus0.valid_o); end
      @(negedge clk);
      #1;
      checks++; if (bus0.valid_o !== 1'b0 || bus0.read_o !== 32'h8) begin failures++; $display("[TB] FAIL s0_drain: got %b/%h expected 0/8", bus0.valid_o, bus0.read_o); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            applyStimulus(k, ($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++; if (av[k] !== (mc[k] > 0)) begin failures++; $display("[TB] FAIL rand_valid%0d: got %b expected %b at cycle %0d", k, av[k], (mc[k] > 0), c); end
            checks++; if (ar[k] !== exp_ready(k)) begin failures++; $display("[TB] FAIL rand_ready%0d: got %b expected %b at cycle %0d", k, ar[k], exp_ready(k), c); end
            checks++; if (ad[k] !== exp_read(k)) begin failures++; $display("[TB] FAIL rand_read%0d: got %h expected %h at cycle %0d", k, ad[k], exp_read(k), c); end
            checks++; if (ao[k] !== 2'(mc[k]) || ao[k] > 2'd2) begin failures++; $display("[TB] FAIL rand_occ%0d: got %0d expected %0d at cycle %0d", k, ao[k], mc[k], c); end
         end
      end
      @(negedge clk);
      applyStimulus(0, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_skid0();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It replaces the bare per-stage data flops between IF/ID/EX/MEM/WB. Stalls come from downstream back-pressure and pipeline bubbles from flushes. With the skid buffer enabled, the ready path between stages is fully registered.

## Interface
- `WIDTH`, default 32: payload width in bits (≥1).
- `SKID`, default 1: 1 = two-entry skid buffer with registered `ready_o`; 0 = single entry with combinational `ready_o`.
- `RESET_VAL`, default 0: value loaded into the payload registers on reset and on flush.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  synchronous flush; discards all held entries.
- `valid_i`  in  1  upstream payload valid.
- `ready_o`  out  1  stage can accept; input transfer occurs when `valid_i & ready_o`.
- `write_i`  in  `WIDTH`  upstream payload.
- `valid_o`  out  1  downstream payload valid.
- `ready_i`  in  1  downstream accepts; output transfer occurs when `valid_o & ready_i`.
- `read_o`  out  `WIDTH`  downstream payload (main register).
- `occ_o`  out  2  number of held entries (0..2; max 1 when `SKID`=0).

## Operation
- Reset (`reset_ni`=0, asynchronous):
  - state goes to EMPTY;
  - `valid_o`=0 and `occ_o`=0;
  - main and skid registers load `RESET_VAL`, so `read_o`=`RESET_VAL`;
  - `ready_o`=1.
- Flush (`flush_i`=1 at a clock edge) has the highest priority:
  - the next state is EMPTY and both registers load `RESET_VAL`;
  - any input transfer offered that cycle is dropped, even if `ready_o`=1;
  - any output transfer that cycle still counts as taken downstream.
- SKID=1 state machine. States are EMPTY, ONE (main valid) and TWO (main and skid valid). "In" means an input transfer; "out" means an output transfer.
  - EMPTY: in → main←`write_i`, go to ONE; otherwise stay.
  - ONE, in & out: main←`write_i`, stay in ONE.
  - ONE, out only: go to EMPTY; `read_o` holds its stale value.
  - ONE, in only: skid←`write_i`, go to TWO.
  - ONE, neither: hold.
  - TWO: `ready_o`=0, so no input transfer is possible. Out → main←skid, go to ONE; otherwise hold.
  - `ready_o` = (state≠TWO), decoded directly from state flops with no `ready_i` term.
  - `valid_o` = (state≠EMPTY).
- SKID=0:
  - single entry; `ready_o` = `ready_i` | ~`valid_o`;
  - on in, main←`write_i` and `valid_o`←1;
  - on out without in, `valid_o`←0.
- Ordering: strictly FIFO; no entry is duplicated or lost except by flush.
- `occ_o` encoding: EMPTY=0, ONE=1, TWO=2.

## Timing
- Latency: data accepted at edge N appears on `read_o` with `valid_o`=1 after edge N; downstream can take it at edge N+1.
- Throughput: one transfer per cycle in steady state with `ready_i`=1, for both SKID settings.
- SKID=1: after `ready_i` falls, one additional beat is absorbed (into skid), then `ready_o`=0 from the following cycle. After `ready_i` rises, `ready_o` returns to 1 one cycle later.
- SKID=0: combinational path `ready_i`→`ready_o`; no other combinational input→output paths.
- Simultaneous flush and reset: reset wins (asynchronous).
- Reset deassertion mid-transfer: no transfer completes on the edge where `reset_ni` is low.

## Structure
- Shared package `pipe_pkg` holds:
  - `pipe_state_t` enum: EMPTY=2'b00, ONE=2'b01, TWO=2'b10;
  - constant `PIPE_OCC_W`=2.
- One sub-module, `pipe_data_reg`: `WIDTH`-bit register with load enable, synchronous clear-to-`RESET_VAL` and asynchronous active-low reset. Instantiate it twice (main, skid); only once when `SKID`=0 via a generate branch.

## Test plan
- Reset: assert `reset_ni`=0 mid-cycle with `RESET_VAL`=32'hDEAD_BEEF → immediately `valid_o`=0, `read_o`=32'hDEAD_BEEF, `occ_o`=0, `ready_o`=1.
- Streaming: SKID=1, `ready_i`=1, push 0x1..0x8 back-to-back → `read_o` presents 0x1..0x8 on consecutive cycles one cycle after each push; `ready_o` stays 1 throughout.
- Back-pressure: push 0xA, 0xB, 0xC continuously and drop `ready_i` while 0xA is on `read_o` → 0xB goes to skid, `occ_o`=2, `ready_o`=0, 0xC stalls upstream. Raise `ready_i` → 0xA, 0xB, 0xC emerge in order with nothing lost.
- Flush in TWO with `valid_i`=1, `write_i`=0x55 → next cycle `valid_o`=0, `occ_o`=0, `read_o`=`RESET_VAL`, and 0x55 is never output.
- SKID=0: hold `ready_i`=0 with 0x7 held → `ready_o`=0 in the same cycle; toggle `ready_i`=1 → `ready_o`=1 combinationally and 0x7 is replaced by the next input.
- Random valid/ready/flush for 10k cycles against a scoreboard → outputs match FIFO order between flushes and `occ_o` never exceeds 2.
